// File: rtl/dmem_arbiter_if.sv
// Bundled request/grant/read-data signals for two DataM requesters plus the
// shared DataM port. The arbiter uses the slave modport.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_lock;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] mem_dir;
    logic [DW-1:0] mem_wdata;
    logic          mem_memwrite;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_dir, mem_wdata, mem_memwrite,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_dir, mem_wdata, mem_memwrite,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port DataM between two requesters.
// Optional bounded burst lock enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic           clock,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);
    logic          last_gnt_q, last_gnt_d;
    logic          m0_rvalid_q, m0_rvalid_d;
    logic          m1_rvalid_q, m1_rvalid_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;

    logic gnt_any;
    logic win;
    logic lock_hold;
    logic m0_gnt, m1_gnt;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          prev_req, prev_lock, other_req;

    // The previous winner keeps the port while it locks, until its burst is
    // used up and the other side is actually waiting.
    always_comb begin
        prev_req  = last_gnt_q ? bus.m1_req  : bus.m0_req;
        prev_lock = last_gnt_q ? bus.m1_lock : bus.m0_lock;
        other_req = last_gnt_q ? bus.m0_req  : bus.m1_req;
        lock_hold = prev_req && prev_lock &&
                    !((burst_cnt_q == CW'(MAX_BURST - 1)) && other_req);
    end

    always_comb begin
        burst_cnt_d = '0;
        if (gnt_any && lock_hold) begin
            burst_cnt_d = (burst_cnt_q == CW'(MAX_BURST - 1)) ? burst_cnt_q
                                                              : burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = bus.m0_lock ^ bus.m1_lock;
    assign lock_hold   = 1'b0;
`endif

    always_comb begin
        gnt_any = 1'b0;
        win     = 1'b0;
        if (!Reset) begin
            if (lock_hold) begin
                gnt_any = 1'b1;
                win     = last_gnt_q;
            end else if (bus.m0_req && bus.m1_req) begin
                gnt_any = 1'b1;
                win     = ~last_gnt_q;
            end else if (bus.m0_req) begin
                gnt_any = 1'b1;
                win     = 1'b0;
            end else if (bus.m1_req) begin
                gnt_any = 1'b1;
                win     = 1'b1;
            end
        end
    end

    assign m0_gnt     = gnt_any && !win;
    assign m1_gnt     = gnt_any &&  win;
    assign bus.m0_gnt = m0_gnt;
    assign bus.m1_gnt = m1_gnt;

    always_comb begin
        bus.mem_dir      = '0;
        bus.mem_wdata    = '0;
        bus.mem_memwrite = 1'b0;
        if (m0_gnt) begin
            bus.mem_dir      = bus.m0_addr;
            bus.mem_wdata    = bus.m0_wdata;
            bus.mem_memwrite = bus.m0_we;
        end else if (m1_gnt) begin
            bus.mem_dir      = bus.m1_addr;
            bus.mem_wdata    = bus.m1_wdata;
            bus.mem_memwrite = bus.m1_we;
        end
    end

    // DataM reads combinationally, so the granted read's data is captured on
    // the grant edge; the loser's rdata simply holds.
    always_comb begin
        last_gnt_d  = gnt_any ? win : last_gnt_q;
        m0_rvalid_d = m0_gnt && !bus.m0_we;
        m1_rvalid_d = m1_gnt && !bus.m1_we;
        m0_rdata_d  = m0_rvalid_d ? bus.mem_rdata : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? bus.mem_rdata : m1_rdata_q;
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            last_gnt_q  <= 1'b1;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus reset and lock sequences.
// A small behavioural DataM sits on the memory side.
module tb_dmem_arbiter;
    logic clock;
    logic Reset;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mem [0:255];
    assign bus.mem_rdata = mem[bus.mem_dir[7:0]];
    always @(posedge clock) begin
        if (bus.mem_memwrite) mem[bus.mem_dir[7:0]] <= bus.mem_wdata;
    end

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, mw;
        logic [31:0] dir;
        logic        rv0, rv1;
        logic [31:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input logic g0, input logic g1, input logic mw, input logic [31:0] dir,
        input logic rv0, input logic [31:0] rd0, input logic rv1, input logic [31:0] rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mw = mw; v.dir = dir;
        v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
        return v;
    endfunction

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.m0_lock = 1'b0;
        bus.m1_lock = 1'b0;
        @(negedge clock);
        Reset = 1'b0;
    endtask

    localparam int NV = 10;
    vec_t vecs [NV];

`ifdef DMEM_ARB_LOCK_EN
    localparam int NL = 7;
    logic lock_exp [NL] = '{0, 0, 0, 0, 1, 0, 0};
`else
    localparam int NL = 11;
    logic lock_exp [NL] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        //            r0 w0 a0     d0            r1 w1 a1     d1            g0 g1 mw dir     rv0 rd0           rv1 rd1
        vecs[0] = mk(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        1, 0, 1, 32'h10, 0, 32'h0,        0, 32'h0);
        vecs[1] = mk(1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h10, 1, 32'hDEADBEEF, 0, 32'h0);
        vecs[2] = mk(1, 0, 32'h20, 32'h0,        1, 1, 32'h20, 32'h12345678, 0, 1, 1, 32'h20, 0, 32'h0,        0, 32'h0);
        vecs[3] = mk(1, 0, 32'h20, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h20, 1, 32'h12345678, 0, 32'h0);
        vecs[4] = mk(1, 0, 32'h10, 32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 0, 32'h0,        1, 32'h12345678);
        vecs[5] = mk(1, 0, 32'h10, 32'h0,        1, 0, 32'h20, 32'h0,        1, 0, 0, 32'h10, 1, 32'hDEADBEEF, 0, 32'h0);
        vecs[6] = mk(0, 0, 32'h10, 32'h0,        0, 0, 32'h20, 32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        0, 32'h0);
        vecs[7] = mk(1, 0, 32'h10, 32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 0, 32'h0,        1, 32'h12345678);
        vecs[8] = mk(0, 0, 32'h0,  32'h0,        1, 1, 32'h30, 32'hCAFEF00D, 0, 1, 1, 32'h30, 0, 32'h0,        0, 32'h0);
        vecs[9] = mk(0, 0, 32'h0,  32'h0,        1, 0, 32'h30, 32'h0,        0, 1, 0, 32'h30, 0, 32'h0,        1, 32'hCAFEF00D);

        // Reset state, with requests present
        Reset = 1'b1;
        bus.m0_lock = 1'b0;
        bus.m1_lock = 1'b0;
        drive(1, 1, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2);
        repeat (2) @(negedge clock);
        chk("rst_gnt0", {31'b0, bus.m0_gnt}, 32'h0);
        chk("rst_gnt1", {31'b0, bus.m1_gnt}, 32'h0);
        chk("rst_memwrite", {31'b0, bus.mem_memwrite}, 32'h0);
        chk("rst_rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 32'h0);
        chk("rst_rdata0", bus.m0_rdata, 32'h0);
        chk("rst_rdata1", bus.m1_rdata, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            #1;
            chk($sformatf("v%0d_gnt", i), {30'b0, bus.m1_gnt, bus.m0_gnt}, {30'b0, vecs[i].g1, vecs[i].g0});
            chk($sformatf("v%0d_memwrite", i), {31'b0, bus.mem_memwrite}, {31'b0, vecs[i].mw});
            chk($sformatf("v%0d_dir", i), bus.mem_dir, vecs[i].dir);
            if (vecs[i].mw) chk($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].g0 ? vecs[i].d0 : vecs[i].d1);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_rvalid", i), {30'b0, bus.m1_rvalid, bus.m0_rvalid}, {30'b0, vecs[i].rv1, vecs[i].rv0});
            if (vecs[i].rv0) chk($sformatf("v%0d_rdata0", i), bus.m0_rdata, vecs[i].rd0);
            if (vecs[i].rv1) chk($sformatf("v%0d_rdata1", i), bus.m1_rdata, vecs[i].rd1);
            $display("vec %0d: gnt=%b%b mw=%b dir=0x%0h rv=%b%b", i, bus.m1_gnt, bus.m0_gnt,
                     bus.mem_memwrite, bus.mem_dir, bus.m1_rvalid, bus.m0_rvalid);
        end

        // Continuous contention straight out of reset alternates from m0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clock);
            drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
            #1;
            chk($sformatf("alt%0d_gnt", i), {30'b0, bus.m1_gnt, bus.m0_gnt}, (i % 2 == 0) ? 32'h1 : 32'h2);
            @(posedge clock);
            #1;
            chk($sformatf("alt%0d_rvalid", i), {30'b0, bus.m1_rvalid, bus.m0_rvalid}, (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("alt%0d_rdata", i), (i % 2 == 0) ? bus.m0_rdata : bus.m1_rdata,
                (i % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
            $display("alt %0d: gnt=%b%b", i, bus.m1_gnt, bus.m0_gnt);
        end

        // Reset mid-cycle clears a pending rvalid at once and blocks writes
        #1;
        Reset = 1'b1;
        bus.m1_we = 1'b1;
        #1;
        chk("rstmid_rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 32'h0);
        chk("rstmid_gnt", {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'h0);
        chk("rstmid_memwrite", {31'b0, bus.mem_memwrite}, 32'h0);
        @(negedge clock);
        Reset = 1'b0;
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        #1;
        chk("rstrel_gnt", {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'h1);
        // Reset hits before the edge of a granted read: the result is dropped
        #2;
        Reset = 1'b1;
        @(posedge clock);
        #1;
        chk("inflight_rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 32'h0);
        @(negedge clock);
        Reset = 1'b0;
        #1;
        chk("rstrel2_gnt", {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'h1);
        $display("reset seq: gnt=%b%b after release", bus.m1_gnt, bus.m0_gnt);

        // m0 locks for six transfers against continuous m1 traffic
        do_reset();
        begin
            int m0_left;
            m0_left = 6;
            for (int c = 0; c < NL; c++) begin
                if (c != 0) @(negedge clock);
                drive(m0_left > 0, 0, 32'h10, 0, 1, 0, 32'h20, 0);
                bus.m0_lock = (m0_left > 0);
                #1;
                chk($sformatf("lock%0d_gnt", c), {30'b0, bus.m1_gnt, bus.m0_gnt},
                    lock_exp[c] ? 32'h2 : 32'h1);
                $display("lock %0d: gnt=%b%b", c, bus.m1_gnt, bus.m0_gnt);
                if (bus.m0_gnt) m0_left--;
                @(posedge clock);
            end
            chk("lock_m0_done", m0_left, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
